// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: serialises mepc/mcause/mtval/mstatus updates on trap entry
// or mret through the shared CSR write port, then issues a one-cycle PC redirect.
module trap_ctrl #(
    parameter int unsigned DATA_BUS_WIDTH = 32,
    parameter int unsigned CSR_BUS_WIDTH  = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      exc_vld_i,
    input  logic [DATA_BUS_WIDTH-1:0] exc_cause_i,
    input  logic [DATA_BUS_WIDTH-1:0] exc_pc_i,
    input  logic [DATA_BUS_WIDTH-1:0] exc_tval_i,
    input  logic                      irq_i,
    input  logic [DATA_BUS_WIDTH-1:0] irq_pc_i,
    input  logic                      mret_i,
    input  logic                      inst_csr_we_i,
    input  logic [CSR_BUS_WIDTH-1:0]  inst_csr_waddr_i,
    input  logic [DATA_BUS_WIDTH-1:0] inst_csr_wdata_i,
    input  logic [DATA_BUS_WIDTH-1:0] csr_mtvec_i,
    input  logic [DATA_BUS_WIDTH-1:0] csr_mepc_i,
    input  logic [DATA_BUS_WIDTH-1:0] csr_mstatus_i,
    output logic [CSR_BUS_WIDTH-1:0]  csr_waddr_o,
    output logic                      csr_waddr_vld_o,
    output logic [DATA_BUS_WIDTH-1:0] csr_wdata_o,
    output logic                      stall_o,
    output logic                      flush_o,
    output logic                      redirect_vld_o,
    output logic [DATA_BUS_WIDTH-1:0] redirect_pc_o
);

    typedef enum logic [2:0] {
        StIdle, StWMepc, StWMcause, StWMtval, StWMstatus, StJump
    } state_e;

    typedef enum logic {KindTrap, KindMret} kind_e;

    state_e                    state_q, state_d;
    kind_e                     kind_q, kind_d;
    logic [DATA_BUS_WIDTH-1:0] epc_q, epc_d;
    logic [DATA_BUS_WIDTH-1:0] cause_q, cause_d;
    logic [DATA_BUS_WIDTH-1:0] tval_q, tval_d;

    logic                      take_exc, take_mret, take_irq;
    logic [DATA_BUS_WIDTH-1:0] mstatus_trap, mstatus_mret;
    logic [DATA_BUS_WIDTH-1:0] tvec_base, tvec_off;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            kind_q  <= KindTrap;
            epc_q   <= '0;
            cause_q <= '0;
            tval_q  <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            tval_q  <= tval_d;
        end
    end

    assign take_exc  = exc_vld_i;
    assign take_mret = !exc_vld_i && mret_i;
    assign take_irq  = !exc_vld_i && !mret_i && irq_i && csr_mstatus_i[3];

    always_comb begin
        mstatus_trap        = csr_mstatus_i;
        mstatus_trap[7]     = csr_mstatus_i[3];
        mstatus_trap[3]     = 1'b0;
        mstatus_trap[12:11] = 2'b11;
        mstatus_mret        = csr_mstatus_i;
        mstatus_mret[3]     = csr_mstatus_i[7];
        mstatus_mret[7]     = 1'b1;
        mstatus_mret[12:11] = 2'b11;
        tvec_base           = {csr_mtvec_i[DATA_BUS_WIDTH-1:2], 2'b00};
        tvec_off            = DATA_BUS_WIDTH'({cause_q[4:0], 2'b00});
    end

    always_comb begin
        state_d         = state_q;
        kind_d          = kind_q;
        epc_d           = epc_q;
        cause_d         = cause_q;
        tval_d          = tval_q;
        csr_waddr_o     = '0;
        csr_waddr_vld_o = 1'b0;
        csr_wdata_o     = '0;
        stall_o         = 1'b1;
        flush_o         = 1'b0;
        redirect_vld_o  = 1'b0;
        redirect_pc_o   = '0;

        unique case (state_q)
            StIdle: begin
                stall_o = 1'b0;
                if (take_exc || take_irq) begin
                    flush_o = 1'b1;
                    kind_d  = KindTrap;
                    state_d = StWMepc;
                    epc_d   = take_exc ? exc_pc_i : irq_pc_i;
                    cause_d = take_exc ? exc_cause_i : DATA_BUS_WIDTH'(32'h8000_000B);
                    tval_d  = take_exc ? exc_tval_i : '0;
                end else if (take_mret) begin
                    flush_o = 1'b1;
                    kind_d  = KindMret;
                    state_d = StWMstatus;
                end else begin
                    csr_waddr_vld_o = inst_csr_we_i;
                    csr_waddr_o     = inst_csr_waddr_i;
                    csr_wdata_o     = inst_csr_wdata_i;
                end
            end
            StWMepc: begin
                csr_waddr_vld_o = 1'b1;
                csr_waddr_o     = CSR_BUS_WIDTH'(12'h341);
                csr_wdata_o     = epc_q;
                state_d         = StWMcause;
            end
            StWMcause: begin
                csr_waddr_vld_o = 1'b1;
                csr_waddr_o     = CSR_BUS_WIDTH'(12'h342);
                csr_wdata_o     = cause_q;
                state_d         = StWMtval;
            end
            StWMtval: begin
                csr_waddr_vld_o = 1'b1;
                csr_waddr_o     = CSR_BUS_WIDTH'(12'h343);
                csr_wdata_o     = tval_q;
                state_d         = StWMstatus;
            end
            StWMstatus: begin
                csr_waddr_vld_o = 1'b1;
                csr_waddr_o     = CSR_BUS_WIDTH'(12'h300);
                csr_wdata_o     = (kind_q == KindMret) ? mstatus_mret : mstatus_trap;
                state_d         = StJump;
            end
            StJump: begin
                redirect_vld_o = 1'b1;
                state_d        = StIdle;
                // Vectored only for mode 1 with an interrupt cause; modes 2/3 fall back to direct
                if (kind_q == KindMret) begin
                    redirect_pc_o = csr_mepc_i;
                end else if (csr_mtvec_i[1:0] == 2'b01 && cause_q[DATA_BUS_WIDTH-1]) begin
                    redirect_pc_o = tvec_base + tvec_off;
                end else begin
                    redirect_pc_o = tvec_base;
                end
            end
            default: state_d = StIdle;
        endcase

        // Nothing may reach the CSR file or the pipeline while reset is held
        if (!rst_n_i) begin
            csr_waddr_vld_o = 1'b0;
            flush_o         = 1'b0;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus pushes expected CSR writes/redirects with their
// cycle numbers; a negedge monitor pops and compares every output event.
module tb_trap_ctrl;

    logic        clk;
    logic        rst_n;
    logic        exc_vld;
    logic [31:0] exc_cause, exc_pc, exc_tval;
    logic        irq;
    logic [31:0] irq_pc;
    logic        mret;
    logic        inst_we;
    logic [11:0] inst_waddr;
    logic [31:0] inst_wdata;
    logic [31:0] mtvec, mepc, mstatus;
    logic [11:0] csr_waddr;
    logic        csr_wvld;
    logic [31:0] csr_wdata;
    logic        stall, flush, redir_vld;
    logic [31:0] redir_pc;

    typedef struct packed {
        logic        is_redir;
        logic [11:0] addr;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    ev_t exp_q[$];
    int  cyc;
    int  checks;
    int  errors;

    trap_ctrl #(.DATA_BUS_WIDTH(32), .CSR_BUS_WIDTH(12)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .exc_vld_i       (exc_vld),
        .exc_cause_i     (exc_cause),
        .exc_pc_i        (exc_pc),
        .exc_tval_i      (exc_tval),
        .irq_i           (irq),
        .irq_pc_i        (irq_pc),
        .mret_i          (mret),
        .inst_csr_we_i   (inst_we),
        .inst_csr_waddr_i(inst_waddr),
        .inst_csr_wdata_i(inst_wdata),
        .csr_mtvec_i     (mtvec),
        .csr_mepc_i      (mepc),
        .csr_mstatus_i   (mstatus),
        .csr_waddr_o     (csr_waddr),
        .csr_waddr_vld_o (csr_wvld),
        .csr_wdata_o     (csr_wdata),
        .stall_o         (stall),
        .flush_o         (flush),
        .redirect_vld_o  (redir_vld),
        .redirect_pc_o   (redir_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic r, input logic [11:0] a, input logic [31:0] d, input int c);
        ev_t e;
        e.is_redir = r;
        e.addr     = a;
        e.data     = d;
        e.cyc      = c;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every write strobe or redirect must match the head of the scoreboard
    always @(negedge clk) begin
        ev_t g, e;
        if (cyc >= 1) begin
            if (csr_wvld === 1'b1 || redir_vld === 1'b1) begin
                g.is_redir = redir_vld;
                g.addr     = redir_vld ? 12'h000 : csr_waddr;
                g.data     = redir_vld ? redir_pc : csr_wdata;
                g.cyc      = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got redir=%0b addr=0x%03h data=0x%08h cyc=%0d, expected none",
                             g.is_redir, g.addr, g.data, g.cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (g !== e || (csr_wvld === 1'b1 && redir_vld === 1'b1)) begin
                        errors++;
                        $display("FAIL event: got redir=%0b addr=0x%03h data=0x%08h cyc=%0d, expected redir=%0b addr=0x%03h data=0x%08h cyc=%0d",
                                 g.is_redir, g.addr, g.data, g.cyc, e.is_redir, e.addr, e.data, e.cyc);
                    end
                end
            end
            if (redir_vld !== 1'b1) begin
                checks++;
                if (redir_pc !== 32'h0) begin
                    errors++;
                    $display("FAIL redirect_pc_idle: got 0x%08h, expected 0x00000000", redir_pc);
                end
            end
        end
    end

    initial begin
        int t;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        exc_vld = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
        irq = 1'b0; irq_pc = '0; mret = 1'b0;
        inst_we = 1'b1; inst_waddr = 12'h340; inst_wdata = 32'h1;
        mtvec = 32'h100; mepc = '0; mstatus = 32'h8;

        // Reset: outputs quiet, pass-through suppressed while reset is held
        repeat (3) step();
        check("rst_wvld", {31'b0, csr_wvld}, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_flush", {31'b0, flush}, 32'h0);
        check("rst_redir", {31'b0, redir_vld}, 32'h0);
        inst_we = 1'b0;
        rst_n = 1'b1;
        step();

        // Direct-mode exception
        mtvec = 32'h100; mstatus = 32'h8;
        exc_vld = 1'b1; exc_cause = 32'h2; exc_pc = 32'h2040; exc_tval = 32'hDEAD_BEEF;
        t = cyc;
        push(0, 12'h341, 32'h2040, t + 1);
        push(0, 12'h342, 32'h2, t + 2);
        push(0, 12'h343, 32'hDEAD_BEEF, t + 3);
        push(0, 12'h300, 32'h1880, t + 4);
        push(1, 12'h000, 32'h100, t + 5);
        #1;
        check("exc_flush_T", {31'b0, flush}, 32'h1);
        check("exc_stall_T", {31'b0, stall}, 32'h0);
        step();
        exc_vld = 1'b0;
        #1;
        check("exc_flush_T1", {31'b0, flush}, 32'h0);
        check("exc_stall_T1", {31'b0, stall}, 32'h1);
        repeat (4) step();
        check("exc_stall_T5", {31'b0, stall}, 32'h1);
        step();
        check("exc_stall_T6", {31'b0, stall}, 32'h0);

        // Vectored interrupt; CSR file clears MIE at JUMP so no re-entry at T+6
        mtvec = 32'h1001; mstatus = 32'h8; irq = 1'b1; irq_pc = 32'h400;
        t = cyc;
        push(0, 12'h341, 32'h400, t + 1);
        push(0, 12'h342, 32'h8000_000B, t + 2);
        push(0, 12'h343, 32'h0, t + 3);
        push(0, 12'h300, 32'h1880, t + 4);
        push(1, 12'h000, 32'h102C, t + 5);
        #1;
        check("irq_flush_T", {31'b0, flush}, 32'h1);
        repeat (5) step();
        mstatus = 32'h1880;
        step();
        check("irq_masked_after_entry", {31'b0, flush}, 32'h0);
        irq = 1'b0;
        step();

        // Mret
        mepc = 32'h2044; mstatus = 32'h1880; mret = 1'b1;
        t = cyc;
        push(0, 12'h300, 32'h1888, t + 1);
        push(1, 12'h000, 32'h2044, t + 2);
        #1;
        check("mret_flush_T", {31'b0, flush}, 32'h1);
        step();
        mret = 1'b0;
        #1;
        check("mret_stall_T1", {31'b0, stall}, 32'h1);
        repeat (2) step();
        check("mret_stall_T3", {31'b0, stall}, 32'h0);

        // Simultaneous events: exception wins, instruction write dropped and ignored while busy
        mtvec = 32'h100; mstatus = 32'h8;
        exc_vld = 1'b1; exc_cause = 32'h7; exc_pc = 32'h3000; exc_tval = 32'h55;
        mret = 1'b1; irq = 1'b1; irq_pc = 32'h999;
        inst_we = 1'b1; inst_waddr = 12'h340; inst_wdata = 32'hAAAA;
        t = cyc;
        push(0, 12'h341, 32'h3000, t + 1);
        push(0, 12'h342, 32'h7, t + 2);
        push(0, 12'h343, 32'h55, t + 3);
        push(0, 12'h300, 32'h1880, t + 4);
        push(1, 12'h000, 32'h100, t + 5);
        step();
        exc_vld = 1'b0; mret = 1'b0; irq = 1'b0;
        repeat (4) step();
        inst_we = 1'b0;
        mstatus = 32'h1880;
        step();

        // Pass-through in IDLE, same cycle
        inst_we = 1'b1; inst_waddr = 12'h340; inst_wdata = 32'h1234_5678;
        push(0, 12'h340, 32'h1234_5678, cyc);
        step();
        inst_we = 1'b0;

        // Masked interrupt, then MIE set by an instruction write; mtvec mode 3 acts as direct
        mtvec = 32'h1003; mstatus = 32'h0; irq = 1'b1; irq_pc = 32'h500;
        inst_we = 1'b1; inst_waddr = 12'h300; inst_wdata = 32'h8;
        push(0, 12'h300, 32'h8, cyc);
        #1;
        check("masked_irq_flush", {31'b0, flush}, 32'h0);
        step();
        inst_we = 1'b0; mstatus = 32'h8;
        t = cyc;
        push(0, 12'h341, 32'h500, t + 1);
        push(0, 12'h342, 32'h8000_000B, t + 2);
        push(0, 12'h343, 32'h0, t + 3);
        push(0, 12'h300, 32'h1880, t + 4);
        push(1, 12'h000, 32'h1000, t + 5);
        #1;
        check("unmasked_irq_flush", {31'b0, flush}, 32'h1);
        repeat (5) step();
        mstatus = 32'h1880; irq = 1'b0;
        step();

        // Reset in W_MCAUSE aborts the sequence
        mtvec = 32'h100; mstatus = 32'h8;
        exc_vld = 1'b1; exc_cause = 32'h5; exc_pc = 32'h6000; exc_tval = 32'h1;
        push(0, 12'h341, 32'h6000, cyc + 1);
        step();
        exc_vld = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("rst_mid_wvld", {31'b0, csr_wvld}, 32'h0);
        step();
        check("rst_mid_stall", {31'b0, stall}, 32'h0);
        check("rst_mid_flush", {31'b0, flush}, 32'h0);
        check("rst_mid_redir", {31'b0, redir_vld}, 32'h0);
        check("rst_mid_redir_pc", redir_pc, 32'h0);
        rst_n = 1'b1;
        #1;
        check("rst_mid_idle_stall", {31'b0, stall}, 32'h0);
        repeat (6) step();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        while (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: got nothing, expected redir=%0b addr=0x%03h data=0x%08h cyc=%0d",
                     e.is_redir, e.addr, e.data, e.cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
